// File: rtl/ptp_tx_arb.sv
// ptp_tx_arb
// Frame-level arbiter that shares one network TX stream between the PTP engine
// and host TX traffic. Whole frames are granted; beats of two frames are never
// interleaved. PTP wins contention, but after PTP_BURST consecutive PTP frames
// taken while the host was waiting, the host is given the next grant.
// Frames longer than MAX_BEATS are truncated: the sink sees a forced eof with
// len 0, and the rest of the source frame is acked and dropped.
//
// Optional feature: define PTP_TX_TS_EN to add ts_now / ptp_tx_ts /
// ptp_tx_ts_vld. These capture the timestamp at which a PTP frame's sof beat
// is accepted by the network.
//
// Ports:
//   clk_host, rst_n           clock (posedge) and asynchronous active-low reset
//   ptp_*  / ptp_ack          PTP source beat, framing, valid / accept
//   host_* / host_ack         host source beat, framing, valid / accept
//   tx_*_net / tx_ack_net     muxed network beat, framing, valid / network accept
//   ptp_frm_cnt, host_frm_cnt forwarded frames per port (16 bit, wrapping)
//   err_cnt                   protocol errors (8 bit, saturating)
//   busy                      arbiter not idle
//   ts_now, ptp_tx_ts, ptp_tx_ts_vld   (PTP_TX_TS_EN only) sof timestamp capture

module ptp_tx_arb #(
  parameter int WIDTH     = 64,
  parameter int MAX_BEATS = 256,
  parameter int PTP_BURST = 4
) (
  input  logic             clk_host,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ptp_data,
  input  logic [2:0]       ptp_len,
  input  logic             ptp_sof,
  input  logic             ptp_eof,
  input  logic             ptp_vld,
  output logic             ptp_ack,
  input  logic [WIDTH-1:0] host_data,
  input  logic [2:0]       host_len,
  input  logic             host_sof,
  input  logic             host_eof,
  input  logic             host_vld,
  output logic             host_ack,
  output logic [WIDTH-1:0] tx_data_net,
  output logic [2:0]       tx_len_net,
  output logic             tx_sof_net,
  output logic             tx_eof_net,
  output logic             tx_vld_net,
  input  logic             tx_ack_net,
  output logic [15:0]      ptp_frm_cnt,
  output logic [15:0]      host_frm_cnt,
  output logic [7:0]       err_cnt,
  output logic             busy
`ifdef PTP_TX_TS_EN
  ,
  input  logic [31:0]      ts_now,
  output logic [31:0]      ptp_tx_ts,
  output logic             ptp_tx_ts_vld
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PTP   = 2'd1,
    S_HOST  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [9:0] LAST_BEAT = 10'(MAX_BEATS - 1);
  localparam logic [3:0] BURST_MAX = 4'(PTP_BURST);

  state_t      state_reg, state_next;
  logic [9:0]  beat_cnt_reg, beat_cnt_next;
  logic [3:0]  burst_cnt_reg, burst_cnt_next;
  // Host had a frame waiting when the current PTP grant was taken.
  logic        host_pend_reg, host_pend_next;
  // Which source is being drained after truncation (1 = host).
  logic        drain_host_reg, drain_host_next;
  logic [15:0] ptp_frm_cnt_reg, ptp_frm_cnt_next;
  logic [15:0] host_frm_cnt_reg, host_frm_cnt_next;
  logic [7:0]  err_cnt_reg, err_cnt_next;

  logic             ptp_req, host_req;
  logic             sel_host;
  logic [WIDTH-1:0] src_data;
  logic [2:0]       src_len;
  logic             src_sof, src_eof, src_vld;
  logic             in_frame, xfer, trunc;
  logic [1:0]       err_inc;
  logic [8:0]       err_sum;

  assign ptp_req  = ptp_vld && ptp_sof;
  assign host_req = host_vld && host_sof;

  // Source mux, steered by the registered grant.
  assign sel_host = (state_reg == S_HOST);
  assign src_data = sel_host ? host_data : ptp_data;
  assign src_len  = sel_host ? host_len  : ptp_len;
  assign src_sof  = sel_host ? host_sof  : ptp_sof;
  assign src_eof  = sel_host ? host_eof  : ptp_eof;
  assign src_vld  = sel_host ? host_vld  : ptp_vld;

  assign in_frame = (state_reg == S_PTP) || (state_reg == S_HOST);
  assign xfer     = in_frame && src_vld && tx_ack_net;
  // Last permitted beat without an eof from the source: force the frame closed.
  assign trunc    = (beat_cnt_reg == LAST_BEAT) && !src_eof;

  always_ff @(posedge clk_host or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      beat_cnt_reg     <= '0;
      burst_cnt_reg    <= '0;
      host_pend_reg    <= 1'b0;
      drain_host_reg   <= 1'b0;
      ptp_frm_cnt_reg  <= '0;
      host_frm_cnt_reg <= '0;
      err_cnt_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      beat_cnt_reg     <= beat_cnt_next;
      burst_cnt_reg    <= burst_cnt_next;
      host_pend_reg    <= host_pend_next;
      drain_host_reg   <= drain_host_next;
      ptp_frm_cnt_reg  <= ptp_frm_cnt_next;
      host_frm_cnt_reg <= host_frm_cnt_next;
      err_cnt_reg      <= err_cnt_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    beat_cnt_next     = beat_cnt_reg;
    burst_cnt_next    = burst_cnt_reg;
    host_pend_next    = host_pend_reg;
    drain_host_next   = drain_host_reg;
    ptp_frm_cnt_next  = ptp_frm_cnt_reg;
    host_frm_cnt_next = host_frm_cnt_reg;
    err_inc           = 2'd0;
    ptp_ack           = 1'b0;
    host_ack          = 1'b0;
    tx_data_net       = '0;
    tx_len_net        = 3'd0;
    tx_sof_net        = 1'b0;
    tx_eof_net        = 1'b0;
    tx_vld_net        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Beats without sof outside a frame are orphans: swallow and count.
        ptp_ack        = ptp_vld && !ptp_sof;
        host_ack       = host_vld && !host_sof;
        err_inc        = {1'b0, ptp_ack} + {1'b0, host_ack};
        host_pend_next = host_req;
        if (ptp_req && host_req) begin
          state_next = (burst_cnt_reg == BURST_MAX) ? S_HOST : S_PTP;
        end else if (ptp_req) begin
          state_next = S_PTP;
        end else if (host_req) begin
          state_next = S_HOST;
        end
      end

      S_PTP, S_HOST: begin
        tx_vld_net  = src_vld;
        tx_data_net = src_data;
        tx_len_net  = trunc ? 3'd0 : src_len;
        // Only the first beat of a granted frame may carry sof.
        tx_sof_net  = src_sof && (beat_cnt_reg == 10'd0);
        tx_eof_net  = src_eof || trunc;
        if (sel_host) host_ack = tx_ack_net;
        else          ptp_ack  = tx_ack_net;

        if (xfer) begin
          beat_cnt_next = beat_cnt_reg + 10'd1;
          if (src_sof && (beat_cnt_reg != 10'd0)) err_inc = err_inc + 2'd1;
          if (tx_eof_net) begin
            beat_cnt_next = '0;
            if (sel_host) begin
              host_frm_cnt_next = host_frm_cnt_reg + 16'd1;
              burst_cnt_next    = '0;
            end else begin
              ptp_frm_cnt_next = ptp_frm_cnt_reg + 16'd1;
              if (host_pend_reg && (burst_cnt_reg != 4'hF))
                burst_cnt_next = burst_cnt_reg + 4'd1;
            end
            if (trunc) begin
              state_next      = S_DRAIN;
              drain_host_next = sel_host;
              err_inc         = err_inc + 2'd1;
            end else begin
              state_next = S_IDLE;
            end
          end
        end
      end

      S_DRAIN: begin
        if (drain_host_reg) begin
          host_ack = 1'b1;
          if (host_vld && host_eof) state_next = S_IDLE;
        end else begin
          ptp_ack = 1'b1;
          if (ptp_vld && ptp_eof) state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase

    err_sum      = {1'b0, err_cnt_reg} + {7'd0, err_inc};
    err_cnt_next = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  assign ptp_frm_cnt  = ptp_frm_cnt_reg;
  assign host_frm_cnt = host_frm_cnt_reg;
  assign err_cnt      = err_cnt_reg;
  assign busy         = (state_reg != S_IDLE);

`ifdef PTP_TX_TS_EN
  logic [31:0] ptp_tx_ts_reg;
  logic        ptp_tx_ts_vld_reg;
  logic        ts_capture;

  assign ts_capture = xfer && !sel_host && (beat_cnt_reg == 10'd0);

  always_ff @(posedge clk_host or negedge rst_n) begin
    if (!rst_n) begin
      ptp_tx_ts_reg     <= '0;
      ptp_tx_ts_vld_reg <= 1'b0;
    end else begin
      ptp_tx_ts_vld_reg <= ts_capture;
      if (ts_capture) ptp_tx_ts_reg <= ts_now;
    end
  end

  assign ptp_tx_ts     = ptp_tx_ts_reg;
  assign ptp_tx_ts_vld = ptp_tx_ts_vld_reg;
`endif

endmodule

// File: tb/tb_ptp_tx_arb.sv
// Directed testbench for ptp_tx_arb (WIDTH=64, MAX_BEATS=256, PTP_BURST=4).
// Sources are modelled as beat queues presented with vld/ack handshaking;
// every accepted network beat is logged for later comparison.
module tb_ptp_tx_arb;

  logic        clk_host = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ptp_data, host_data, tx_data_net;
  logic [2:0]  ptp_len, host_len, tx_len_net;
  logic        ptp_sof, ptp_eof, ptp_vld, ptp_ack;
  logic        host_sof, host_eof, host_vld, host_ack;
  logic        tx_sof_net, tx_eof_net, tx_vld_net;
  logic        tx_ack_net = 1'b1;
  logic [15:0] ptp_frm_cnt, host_frm_cnt;
  logic [7:0]  err_cnt;
  logic        busy;
`ifdef PTP_TX_TS_EN
  logic [31:0] ts_now = '0;
  logic [31:0] ptp_tx_ts;
  logic        ptp_tx_ts_vld;
`endif

  ptp_tx_arb #(.WIDTH(64), .MAX_BEATS(256), .PTP_BURST(4)) dut (
    .clk_host(clk_host), .rst_n(rst_n),
    .ptp_data(ptp_data), .ptp_len(ptp_len), .ptp_sof(ptp_sof),
    .ptp_eof(ptp_eof), .ptp_vld(ptp_vld), .ptp_ack(ptp_ack),
    .host_data(host_data), .host_len(host_len), .host_sof(host_sof),
    .host_eof(host_eof), .host_vld(host_vld), .host_ack(host_ack),
    .tx_data_net(tx_data_net), .tx_len_net(tx_len_net), .tx_sof_net(tx_sof_net),
    .tx_eof_net(tx_eof_net), .tx_vld_net(tx_vld_net), .tx_ack_net(tx_ack_net),
    .ptp_frm_cnt(ptp_frm_cnt), .host_frm_cnt(host_frm_cnt),
    .err_cnt(err_cnt), .busy(busy)
`ifdef PTP_TX_TS_EN
    , .ts_now(ts_now), .ptp_tx_ts(ptp_tx_ts), .ptp_tx_ts_vld(ptp_tx_ts_vld)
`endif
  );

  always #5 clk_host = ~clk_host;

  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  l;
    logic        s;
    logic        e;
  } beat_t;

  beat_t ptp_q[$];
  beat_t host_q[$];
  beat_t out_q[$];
  int    out_cyc[$];
  int    cyc = 0;
  logic  p_x = 1'b0, h_x = 1'b0, ack_toggle = 1'b0;
  int    n_pass = 0, n_fail = 0, n_total = 0;

  function automatic beat_t mk(logic [63:0] d, logic [2:0] l, logic s, logic e);
    beat_t b;
    b.d = d; b.l = l; b.s = s; b.e = e;
    return b;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (ptp_q.size() > 0) begin
      ptp_vld = 1'b1; ptp_data = ptp_q[0].d; ptp_len = ptp_q[0].l;
      ptp_sof = ptp_q[0].s; ptp_eof = ptp_q[0].e;
    end else begin
      ptp_vld = 1'b0; ptp_data = '0; ptp_len = '0; ptp_sof = 1'b0; ptp_eof = 1'b0;
    end
    if (host_q.size() > 0) begin
      host_vld = 1'b1; host_data = host_q[0].d; host_len = host_q[0].l;
      host_sof = host_q[0].s; host_eof = host_q[0].e;
    end else begin
      host_vld = 1'b0; host_data = '0; host_len = '0; host_sof = 1'b0; host_eof = 1'b0;
    end
  endtask

  // One clock: retire beats accepted at this edge, present the next ones,
  // then sample handshakes and the network side on the falling edge.
  task automatic tick();
    @(posedge clk_host); #1;
    if (p_x) ptp_q.delete(0);
    if (h_x) host_q.delete(0);
    if (ack_toggle) tx_ack_net = ~tx_ack_net;
    drive();
    @(negedge clk_host);
    cyc++;
    p_x = ptp_vld && ptp_ack;
    h_x = host_vld && host_ack;
    if (tx_vld_net && tx_ack_net) begin
      out_q.push_back(mk(tx_data_net, tx_len_net, tx_sof_net, tx_eof_net));
      out_cyc.push_back(cyc);
    end
  endtask

  task automatic wait_quiet(int budget, string tag);
    int  n = 0;
    logic done;
    do begin
      tick();
      n++;
      done = (ptp_q.size() == 0) && (host_q.size() == 0) && !busy;
    end while (!done && n < budget);
    chk({tag, "_complete"}, done, 1);
  endtask

  task automatic do_reset();
    @(posedge clk_host); #1;
    rst_n = 1'b0;
    ptp_q.delete(); host_q.delete(); out_q.delete(); out_cyc.delete();
    p_x = 1'b0; h_x = 1'b0; ack_toggle = 1'b0; tx_ack_net = 1'b1;
    drive();
    @(posedge clk_host); #1;
    rst_n = 1'b1;
    @(negedge clk_host);
  endtask

  initial begin
    logic [9:0] order;
    drive();

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_tx_vld", tx_vld_net, 0);
    chk("rst_tx_data", tx_data_net, 0);
    chk("rst_tx_len", tx_len_net, 0);
    chk("rst_tx_sof_eof", {tx_sof_net, tx_eof_net}, 0);
    chk("rst_acks", {ptp_ack, host_ack}, 0);
    chk("rst_cnts", {ptp_frm_cnt, host_frm_cnt, err_cnt}, 0);
    do_reset();

    // Single 8-beat host frame, one cycle of arbitration latency
    for (int i = 0; i < 8; i++)
      host_q.push_back(mk(64'h100 + 64'(i), (i == 7) ? 3'd3 : 3'd0, i == 0, i == 7));
    tick();
    chk("t1_arb_cycle_vld", tx_vld_net, 0);
    chk("t1_arb_cycle_ack", host_ack, 0);
    tick();
    chk("t1_first_vld", tx_vld_net, 1);
    chk("t1_first_sof", tx_sof_net, 1);
    chk("t1_first_data", tx_data_net, 64'h100);
    wait_quiet(50, "t1");
    chk("t1_nbeats", out_q.size(), 8);
    for (int i = 0; i < 8 && i < out_q.size(); i++)
      chk($sformatf("t1_data%0d", i), out_q[i].d, 64'h100 + 64'(i));
    if (out_q.size() == 8) chk("t1_last_eof_len", {out_q[7].e, out_q[7].l}, 4'b1011);
    chk("t1_host_frm", host_frm_cnt, 1);
    chk("t1_busy", busy, 0);
    chk("t1_err", err_cnt, 0);

    // Simultaneous PTP and host sof: PTP first, one idle cycle, then host
    do_reset();
    ptp_q.push_back(mk(64'hA0, 3'd0, 1'b1, 1'b0));
    ptp_q.push_back(mk(64'hA1, 3'd0, 1'b0, 1'b1));
    host_q.push_back(mk(64'hB0, 3'd0, 1'b1, 1'b0));
    host_q.push_back(mk(64'hB1, 3'd0, 1'b0, 1'b1));
    wait_quiet(50, "t2");
    chk("t2_nbeats", out_q.size(), 4);
    if (out_q.size() == 4) begin
      chk("t2_order", {out_q[0].d[7:0], out_q[1].d[7:0], out_q[2].d[7:0], out_q[3].d[7:0]},
          32'hA0A1B0B1);
      chk("t2_idle_gap", out_cyc[2] - out_cyc[1], 2);
    end
    chk("t2_ptp_frm", ptp_frm_cnt, 1);
    chk("t2_host_frm", host_frm_cnt, 1);

    // Continuous contention: P,P,P,P,H,P,P,P,P,H
    do_reset();
    for (int i = 0; i < 8; i++) ptp_q.push_back(mk({8'hA0, 56'(i)}, 3'd0, 1'b1, 1'b1));
    for (int i = 0; i < 2; i++) host_q.push_back(mk({8'hB0, 56'(i)}, 3'd0, 1'b1, 1'b1));
    wait_quiet(100, "t3");
    order = '0;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i].s) order = {order[8:0], out_q[i].d[63:56] == 8'hB0};
    chk("t3_grant_order", order, 10'b0000100001);
    chk("t3_frm_cnts", {ptp_frm_cnt, host_frm_cnt}, {16'd8, 16'd2});

    // Network ack toggling: nothing lost or duplicated
    do_reset();
    for (int i = 0; i < 8; i++)
      host_q.push_back(mk(64'(i), 3'd0, i == 0, i == 7));
    ack_toggle = 1'b1;
    wait_quiet(60, "t4");
    ack_toggle = 1'b0;
    tx_ack_net = 1'b1;
    chk("t4_nbeats", out_q.size(), 8);
    for (int i = 0; i < 8 && i < out_q.size(); i++)
      chk($sformatf("t4_data%0d", i), out_q[i].d, 64'(i));

    // 300-beat host frame truncated at 256 beats, rest drained
    do_reset();
    for (int i = 0; i < 300; i++)
      host_q.push_back(mk(64'(i), 3'd5, i == 0, i == 299));
    wait_quiet(400, "t5");
    chk("t5_nbeats", out_q.size(), 256);
    if (out_q.size() == 256) begin
      chk("t5_beat255_eof", out_q[255].e, 1);
      chk("t5_beat255_len", out_q[255].l, 0);
      chk("t5_beat255_data", out_q[255].d, 64'd255);
      chk("t5_beat254_eof", out_q[254].e, 0);
    end
    chk("t5_err", err_cnt, 1);
    chk("t5_host_frm", host_frm_cnt, 1);

    // Orphan host beat in IDLE
    do_reset();
    host_q.push_back(mk(64'hDEAD, 3'd0, 1'b0, 1'b1));
    tick();
    chk("t6_orphan_ack", host_ack, 1);
    chk("t6_orphan_tx_vld", tx_vld_net, 0);
    wait_quiet(10, "t6");
    chk("t6_err", err_cnt, 1);
    chk("t6_nbeats", out_q.size(), 0);
    chk("t6_host_frm", host_frm_cnt, 0);

    // Stray sof mid-frame: forwarded with sof cleared, counted as error
    do_reset();
    for (int i = 0; i < 4; i++)
      host_q.push_back(mk(64'h40 + 64'(i), 3'd0, (i == 0) || (i == 2), i == 3));
    wait_quiet(30, "t7");
    chk("t7_nbeats", out_q.size(), 4);
    if (out_q.size() == 4) chk("t7_beat2_sof", out_q[2].s, 0);
    chk("t7_err", err_cnt, 1);
    chk("t7_host_frm", host_frm_cnt, 1);

    // Reset mid-frame: vld drops at once
    do_reset();
    for (int i = 0; i < 6; i++)
      host_q.push_back(mk(64'(i), 3'd0, i == 0, i == 5));
    tick(); tick(); tick();
    chk("t8_midframe_vld", tx_vld_net, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t8_abort_vld", tx_vld_net, 0);
    chk("t8_abort_busy", busy, 0);
    do_reset();

`ifdef PTP_TX_TS_EN
    // Timestamp captured on the PTP sof transfer
    ts_now = 32'h1234_5678;
    ptp_q.push_back(mk(64'hC0, 3'd0, 1'b1, 1'b0));
    ptp_q.push_back(mk(64'hC1, 3'd0, 1'b0, 1'b1));
    tick();
    tick();
    chk("t9_pre_vld", ptp_tx_ts_vld, 0);
    tick();
    chk("t9_ts_vld", ptp_tx_ts_vld, 1);
    chk("t9_ts", ptp_tx_ts, 32'h1234_5678);
    ts_now = 32'h0;
    tick();
    chk("t9_ts_pulse_end", ptp_tx_ts_vld, 0);
    chk("t9_ts_hold", ptp_tx_ts, 32'h1234_5678);
    wait_quiet(20, "t9");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ptp_tx_arb.md
Name: ptp_tx_arb

Overview:
- Frame-level arbiter sharing the single network TX stream between the PTP engine (Sync/Delay_Req/Follow_Up frames) and host TX traffic.
- Grants whole frames only; never interleaves beats of two frames.
- PTP has priority, with a starvation guard for the host port.
- Enforces a maximum frame length, and keeps per-port frame counters and a protocol-error counter.

Parameters:
- WIDTH, 64, data beat width.
- MAX_BEATS, 256, maximum beats per frame before truncation (range 2..1023).
- PTP_BURST, 4, consecutive PTP grants allowed while host waits before the host is forced a grant (range 1..15).

Ports:
- clk_host  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- ptp_data  in  WIDTH  PTP-engine beat
- ptp_len  in  3  valid-byte code on eof beat (0 = all 8)
- ptp_sof / ptp_eof / ptp_vld  in  1 each  PTP framing and valid
- ptp_ack  out  1  beat accepted from PTP source
- host_data  in  WIDTH  host beat
- host_len  in  3  host valid-byte code
- host_sof / host_eof / host_vld  in  1 each  host framing and valid
- host_ack  out  1  beat accepted from host source
- tx_data_net  out  WIDTH  muxed beat
- tx_len_net  out  3  muxed len
- tx_sof_net / tx_eof_net / tx_vld_net  out  1 each  muxed framing and valid
- tx_ack_net  in  1  network accepts beat
- ptp_frm_cnt  out  16  PTP frames forwarded (wraps)
- host_frm_cnt  out  16  host frames forwarded (wraps)
- err_cnt  out  8  protocol errors (saturates at 255)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async on rst_n low):
  - state = IDLE.
  - All counters, beat_cnt, and burst_cnt = 0.
  - ptp_ack, host_ack, tx_vld_net, tx_sof_net, tx_eof_net = 0.
  - tx_data_net = 0, tx_len_net = 0.
- Transfer rule: a beat transfers when vld and ack are both 1 on a rising edge. Sources must hold data stable while vld=1 and ack=0.
- States: IDLE, PTP, HOST, DRAIN.
- IDLE:
  - A request is vld=1 && sof=1.
  - If only one port requests, grant it.
  - If both request: grant HOST when burst_cnt == PTP_BURST, otherwise grant PTP.
  - The grant is registered. The first beat can transfer in the cycle after the request is seen, so there is 1 cycle of arbitration latency.
  - In IDLE, a vld=1 with sof=0 on either port is acked and discarded, and err_cnt increments (once per beat).
  - Otherwise, all acks are 0 and tx_vld_net = 0 in IDLE.
- PTP / HOST:
  - tx_* = granted source's signals (combinational mux).
  - Granted source's ack = tx_ack_net; the other port's ack = 0.
  - beat_cnt increments on each transfer.
  - On an eof transfer:
    - Return to IDLE, so there is at least 1 idle cycle between frames.
    - Clear beat_cnt and increment the port's frame counter.
    - If the grant was PTP and host_vld && host_sof was pending at the grant, burst_cnt increments.
    - If the grant was HOST, burst_cnt is cleared.
  - A sof=1 beat mid-frame is forwarded as-is with sof forced to 0, and err_cnt increments.
- Truncation:
  - If beat_cnt == MAX_BEATS-1 and the current beat has eof=0, the output beat is driven with tx_eof_net=1 and tx_len_net=0.
  - On that transfer, go to DRAIN, increment err_cnt, and count the frame.
- DRAIN:
  - tx_vld_net = 0.
  - The truncated source's ack = 1; its beats are discarded until its eof transfers, then go to IDLE.
- tx_ack_net low stalls indefinitely. State, beat_cnt, and mux are held, with no timeout.
- Reset mid-frame aborts immediately; the sink sees vld drop with no eof.
- Simultaneous eof and a new sof on the other port: the new sof is served after the IDLE cycle.

Optional Feature:
- Macro: PTP_TX_TS_EN.
- When defined, the block adds:
  - input ts_now[31:0]
  - output ptp_tx_ts[31:0]
  - output ptp_tx_ts_vld (1 bit)
- On the transfer of a PTP frame's sof beat, ptp_tx_ts is registered with ts_now and ptp_tx_ts_vld pulses high for 1 cycle. Both reset to 0.
- When not defined, these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Single 8-beat host frame with tx_ack_net=1:
  - First tx beat appears 1 cycle after host sof.
  - 8 beats are forwarded, host_frm_cnt=1, then busy=0.
- PTP and host sof in the same cycle:
  - The PTP frame (2 beats) is forwarded first.
  - Then 1 idle cycle, then the host frame; both counters = 1.
- Host and PTP both requesting continuously with PTP_BURST=4: grant order is P,P,P,P,H,P,P,P,P,H.
- tx_ack_net toggled 1,0,1,0 during a frame:
  - No beat is lost or duplicated.
  - Output data equals the source sequence 64'h0..64'h7.
- Host frame of 300 beats with MAX_BEATS=256:
  - 256 beats are forwarded, the 256th has eof=1 and len=0.
  - The remaining 44 beats are acked and discarded; err_cnt=1.
- Orphan host beat (vld=1, sof=0) in IDLE: acked, not forwarded, err_cnt=1.
- With PTP_TX_TS_EN and ts_now=32'h1234_5678 at the PTP sof transfer: ptp_tx_ts=32'h1234_5678 with a 1-cycle vld pulse.
